// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : alu_arbiter
// Brief   : Round-robin arbiter sharing one combinational ALU between two
//           valid/ready requesters; result returned on a tagged response.
//           Optional macro ALU_ARBITER_STATS_EN adds per-requester grant counters.
// Revision: 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int BUS_SIZE    = 8,
  parameter int OPCODE_SIZE = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0_valid,
  input  logic [BUS_SIZE-1:0]    req0_num1,
  input  logic [BUS_SIZE-1:0]    req0_num2,
  input  logic [OPCODE_SIZE-1:0] req0_opcode,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [BUS_SIZE-1:0]    req1_num1,
  input  logic [BUS_SIZE-1:0]    req1_num2,
  input  logic [OPCODE_SIZE-1:0] req1_opcode,
  output logic                   req1_ready,
  output logic [BUS_SIZE-1:0]    alu_num1,
  output logic [BUS_SIZE-1:0]    alu_num2,
  output logic [OPCODE_SIZE-1:0] alu_opcode,
  input  logic [BUS_SIZE-1:0]    alu_out,
  input  logic                   alu_carry,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic [BUS_SIZE-1:0]    rsp_data,
  output logic                   rsp_carry
`ifdef ALU_ARBITER_STATS_EN
  ,
  output logic [15:0]            grant_cnt0,
  output logic [15:0]            grant_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;
  logic   cur_id;
  logic   any_valid;
  logic   grant_id;
  logic   accept;

  // Tie goes to whichever requester was not served last.
  always_comb begin
    any_valid  = req0_valid | req1_valid;
    grant_id   = req1_valid & (~req0_valid | ~last_grant);
    accept     = (state == IDLE) & any_valid & ~reset;
    req0_ready = accept & ~grant_id;
    req1_ready = accept & grant_id;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cur_id     <= 1'b0;
      alu_num1   <= '0;
      alu_num2   <= '0;
      alu_opcode <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_carry  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            alu_num1   <= grant_id ? req1_num1   : req0_num1;
            alu_num2   <= grant_id ? req1_num2   : req0_num2;
            alu_opcode <= grant_id ? req1_opcode : req0_opcode;
            cur_id     <= grant_id;
            last_grant <= grant_id;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= alu_out;
          rsp_carry <= alu_carry;
          rsp_id    <= cur_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARBITER_STATS_EN
  // Saturating counters of accepted handshakes per requester.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0 <= 16'h0000;
      grant_cnt1 <= 16'h0000;
    end else begin
      if (req0_ready && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (req1_ready && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`else
  // Grant statistics are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// Self-checking bench for alu_arbiter: a reference ALU drives alu_out/alu_carry,
// handshakes push expected results to a scoreboard that responses are checked against.
module tb_alu_arbiter;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_num1 = '0, req0_num2 = '0, req1_num1 = '0, req1_num2 = '0;
  logic [5:0] req0_opcode = '0, req1_opcode = '0;
  logic       req0_ready, req1_ready;
  logic [7:0] alu_num1, alu_num2, alu_out;
  logic [5:0] alu_opcode;
  logic       alu_carry;
  logic       rsp_valid, rsp_id, rsp_carry;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
`ifdef ALU_ARBITER_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic       id;
    logic [8:0] res;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  function automatic logic [8:0] alu_fn(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      OP_ADD:  return {1'b0, a} + {1'b0, b};
      OP_SUB:  return {1'b0, a} - {1'b0, b};
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      default: return 9'h000;
    endcase
  endfunction

  assign {alu_carry, alu_out} = alu_fn(alu_opcode, alu_num1, alu_num2);

  alu_arbiter #(.BUS_SIZE(8), .OPCODE_SIZE(6)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_num1(req0_num1), .req0_num2(req0_num2),
    .req0_opcode(req0_opcode), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_num1(req1_num1), .req1_num2(req1_num2),
    .req1_opcode(req1_opcode), .req1_ready(req1_ready),
    .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry)
`ifdef ALU_ARBITER_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard producer: every accepted handshake yields one expected response.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (req0_valid && req0_ready) begin
        e.id = 1'b0; e.res = alu_fn(req0_opcode, req0_num1, req0_num2); e.cyc = cyc;
        sb.push_back(e);
      end
      if (req1_valid && req1_ready) begin
        e.id = 1'b1; e.res = alu_fn(req1_opcode, req1_num1, req1_num2); e.cyc = cyc;
        sb.push_back(e);
      end
    end
  end

  function automatic void pop_exp(output exp_t e, output bit ok);
    ok = (sb.size() != 0);
    e.id = 1'b0; e.res = '0; e.cyc = 0;
    if (ok) e = sb.pop_front();
  endfunction

  task automatic do_reset();
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
  endtask

  task automatic issue_op(input bit id, input logic [7:0] a, input logic [7:0] b,
                          input logic [5:0] op, output bit ok);
    ok = 1'b0;
    if (!id) begin req0_num1 = a; req0_num2 = b; req0_opcode = op; req0_valid = 1'b1; end
    else     begin req1_num1 = a; req1_num2 = b; req1_opcode = op; req1_valid = 1'b1; end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((id ? req1_ready : req0_ready) === 1'b1) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    if (!id) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({alu_num1, alu_num2, alu_opcode} !== 22'h0) begin
      fails++; $display("FAIL reset_alu_regs: got %h/%h/%h expected 0", alu_num1, alu_num2, alu_opcode);
    end
    tests++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_carry} !== 11'h0) begin
      fails++; $display("FAIL reset_rsp: got v=%b id=%b d=%h c=%b expected all 0", rsp_valid, rsp_id, rsp_data, rsp_carry);
    end
    tests++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      fails++; $display("FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    sb.delete();
  endtask

  task automatic test_single();
    bit ok; exp_t e;
    rsp_ready = 1'b1;
    issue_op(1'b0, 8'h0F, 8'h01, OP_ADD, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL single_handshake: got no req0_ready expected ready"); end
    @(negedge clk);
    tests++;
    if ({req0_ready, rsp_valid} !== 2'b00) begin
      fails++; $display("FAIL single_ready_pulse: got ready=%b rsp_valid=%b expected 0 0", req0_ready, rsp_valid);
    end
    tests++;
    if ({alu_num1, alu_num2, alu_opcode} !== {8'h0F, 8'h01, OP_ADD}) begin
      fails++; $display("FAIL single_alu_in: got %h/%h/%h expected 0f/01/20", alu_num1, alu_num2, alu_opcode);
    end
    wait_rsp(ok);
    pop_exp(e, ok);
    tests++;
    if (!ok || {rsp_id, rsp_carry, rsp_data} !== 10'h010 || (cyc - e.cyc) != 2) begin
      fails++; $display("FAIL single_rsp: got id=%b c=%b d=%h lat=%0d expected id=0 c=0 d=10 lat=2",
                        rsp_id, rsp_carry, rsp_data, cyc - e.cyc);
    end
  endtask

  task automatic test_carry_passthrough();
    bit ok; exp_t e;
    issue_op(1'b1, 8'hFF, 8'h02, OP_ADD, ok);
    wait_rsp(ok);
    pop_exp(e, ok);
    tests++;
    if (!ok || {rsp_id, rsp_carry, rsp_data} !== 10'h301 || {e.id, e.res} !== 10'h301) begin
      fails++; $display("FAIL carry_rsp: got id=%b c=%b d=%h expected id=1 c=1 d=01", rsp_id, rsp_carry, rsp_data);
    end
    issue_op(1'b0, 8'h12, 8'h34, 6'h3F, ok);
    @(negedge clk);
    tests++;
    if (alu_opcode !== 6'h3F) begin
      fails++; $display("FAIL opcode_passthrough: got %h expected 3f", alu_opcode);
    end
    wait_rsp(ok);
    pop_exp(e, ok);
    tests++;
    if (!ok || {rsp_id, rsp_carry, rsp_data} !== {e.id, e.res}) begin
      fails++; $display("FAIL unknown_op_rsp: got id=%b c=%b d=%h expected id=%b res=%h", rsp_id, rsp_carry, rsp_data, e.id, e.res);
    end
  endtask

  task automatic test_back_to_back();
    int n_hs = 0, n_rsp = 0, c0 = 0, c1 = 0, last_rsp = 0;
    bit g0, g1, ok; exp_t e;
    logic [1:0] ops [4] = '{OP_ADD, OP_SUB, OP_AND, OP_OR};
    do_reset();
    rsp_ready = 1'b1;
    req0_num1 = 8'($urandom); req0_num2 = 8'($urandom); req0_opcode = ops[0] == 2'b0 ? OP_ADD : OP_SUB;
    req1_num1 = 8'($urandom); req1_num2 = 8'($urandom); req1_opcode = OP_SUB;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 60 && n_rsp < 4; i++) begin
      @(negedge clk);
      g0 = req0_ready; g1 = req1_ready;
      if (g0 || g1) begin
        tests++;
        if (g0 !== (n_hs % 2 == 0) || g1 !== (n_hs % 2 == 1)) begin
          fails++; $display("FAIL b2b_grant_order: grant %0d got r0=%b r1=%b expected id %0d", n_hs, g0, g1, n_hs % 2);
        end
        n_hs++;
      end
      if (rsp_valid === 1'b1) begin
        pop_exp(e, ok);
        tests++;
        if (!ok || {rsp_id, rsp_carry, rsp_data} !== {e.id, e.res} || rsp_id !== 1'(n_rsp % 2) ||
            (n_rsp > 0 && cyc - last_rsp != 3)) begin
          fails++; $display("FAIL b2b_rsp: rsp %0d got id=%b c=%b d=%h gap=%0d expected id=%0d res=%h gap=3",
                            n_rsp, rsp_id, rsp_carry, rsp_data, cyc - last_rsp, n_rsp % 2, e.res);
        end
        last_rsp = cyc; n_rsp++;
      end
      @(posedge clk); #1;
      if (g0) begin
        c0++;
        if (c0 >= 2) req0_valid = 1'b0;
        else begin req0_num1 = 8'($urandom); req0_num2 = 8'($urandom); req0_opcode = OP_AND; end
      end
      if (g1) begin
        c1++;
        if (c1 >= 2) req1_valid = 1'b0;
        else begin req1_num1 = 8'($urandom); req1_num2 = 8'($urandom); req1_opcode = OP_OR; end
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tests++;
    if (n_rsp != 4) begin fails++; $display("FAIL b2b_count: got %0d responses expected 4", n_rsp); end
  endtask

  task automatic test_backpressure();
    bit ok; exp_t e; logic [7:0] snap;
    rsp_ready = 1'b0;
    issue_op(1'b1, 8'hA5, 8'h3C, OP_AND, ok);
    wait_rsp(ok);
    snap = rsp_data;
    req0_num1 = 8'h40; req0_num2 = 8'h41; req0_opcode = OP_ADD; req0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if ({rsp_valid, req0_ready, req1_ready} !== 3'b100 || rsp_data !== snap || rsp_data !== 8'h24) begin
        fails++; $display("FAIL bp_hold: cycle %0d got v=%b d=%h r0=%b r1=%b expected v=1 d=24 r0=0 r1=0",
                          i, rsp_valid, rsp_data, req0_ready, req1_ready);
      end
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    pop_exp(e, ok);
    tests++;
    if (!ok || {rsp_valid, rsp_id, rsp_carry, rsp_data} !== {1'b1, e.id, e.res}) begin
      fails++; $display("FAIL bp_rsp: got v=%b id=%b d=%h expected v=1 id=%b res=%h", rsp_valid, rsp_id, rsp_data, e.id, e.res);
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if ({rsp_valid, req0_ready} !== 2'b01) begin
      fails++; $display("FAIL bp_release: got v=%b r0=%b expected v=0 r0=1", rsp_valid, req0_ready);
    end
    @(posedge clk); #1 req0_valid = 1'b0;
    wait_rsp(ok);
    pop_exp(e, ok);
    tests++;
    if (!ok || {rsp_id, rsp_carry, rsp_data} !== 10'h081) begin
      fails++; $display("FAIL bp_next_rsp: got id=%b c=%b d=%h expected id=0 c=0 d=81", rsp_id, rsp_carry, rsp_data);
    end
  endtask

  task automatic test_reset_mid();
    bit ok; exp_t e;
    do_reset();
    rsp_ready = 1'b1;
    issue_op(1'b0, 8'h05, 8'h07, OP_SUB, ok);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (rsp_valid !== 1'b0) begin fails++; $display("FAIL mid_exec_valid: got %b expected 0", rsp_valid); end
    @(negedge clk);
    tests++;
    if ({alu_num1, alu_num2, alu_opcode, rsp_valid, rsp_id, rsp_data, rsp_carry} !== 33'h0) begin
      fails++; $display("FAIL mid_reset_zero: got %h/%h/%h v=%b id=%b d=%h c=%b expected all 0",
                        alu_num1, alu_num2, alu_opcode, rsp_valid, rsp_id, rsp_data, rsp_carry);
    end
    sb.delete();
    req0_num1 = 8'h33; req0_num2 = 8'h11; req0_opcode = OP_ADD; req0_valid = 1'b1;
    req1_num1 = 8'hF0; req1_num2 = 8'h0F; req1_opcode = OP_OR;  req1_valid = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      fails++; $display("FAIL mid_first_grant: got r0=%b r1=%b expected r0=1 r1=0", req0_ready, req1_ready);
    end
    @(posedge clk); #1 req0_valid = 1'b0;
    wait_rsp(ok);
    pop_exp(e, ok);
    tests++;
    if (!ok || {rsp_id, rsp_carry, rsp_data} !== 10'h044) begin
      fails++; $display("FAIL mid_rsp0: got id=%b c=%b d=%h expected id=0 c=0 d=44", rsp_id, rsp_carry, rsp_data);
    end
    issue_op(1'b1, 8'hF0, 8'h0F, OP_OR, ok);
    wait_rsp(ok);
    pop_exp(e, ok);
    tests++;
    if (!ok || {rsp_id, rsp_carry, rsp_data} !== 10'h2FF) begin
      fails++; $display("FAIL mid_rsp1: got id=%b c=%b d=%h expected id=1 c=0 d=ff", rsp_id, rsp_carry, rsp_data);
    end
  endtask

`ifdef ALU_ARBITER_STATS_EN
  task automatic test_stats();
    bit ok;
    do_reset();
    rsp_ready = 1'b1;
    tests++;
    if ({grant_cnt0, grant_cnt1} !== 32'h0) begin
      fails++; $display("FAIL stats_init: got %0d/%0d expected 0/0", grant_cnt0, grant_cnt1);
    end
    for (int i = 0; i < 5; i++) begin
      issue_op(i >= 3, 8'(i), 8'h01, OP_ADD, ok);
      wait_rsp(ok);
    end
    @(negedge clk);
    tests++;
    if (grant_cnt0 !== 16'd3 || grant_cnt1 !== 16'd2) begin
      fails++; $display("FAIL stats_count: got %0d/%0d expected 3/2", grant_cnt0, grant_cnt1);
    end
    do_reset();
    @(negedge clk);
    tests++;
    if ({grant_cnt0, grant_cnt1} !== 32'h0) begin
      fails++; $display("FAIL stats_clear: got %0d/%0d expected 0/0", grant_cnt0, grant_cnt1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_carry_passthrough();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef ALU_ARBITER_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
